register_file: RTL and testbench

Parametrised multi-entry successor to the single 32-bit `flipflop32`, used as the processor's general-purpose register store. It holds DEPTH words of WIDTH bits and adds an asynchronous active-low reset, write enable, synchronous bulk clear, two independent read ports, an optional hard-wired zero register and optional write-to-read bypass. Writes are edge-triggered on `clk`; reads are combinational.

---
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register store: DEPTH x WIDTH words, one write port and
// two independent combinational read ports with optional zero register and bypass.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_wr_hit;

    // One-hot write select; out-of-range addresses match no entry, so they drop out naturally.
    always_comb begin
        w_wr_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_wr_hit[i] = we && !clr && (waddr == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_wr_hit[i]) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                v = (BYPASS != 0 && w_wr_hit[i]) ? wdata : r_mem[i];
            end
        end
        return v;
    endfunction

    always_comb rdata_a = f_read(raddr_a);
    always_comb rdata_b = f_read(raddr_b);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: three builds (default, DEPTH=12,
// no zero register / no bypass) share stimulus and are compared to a reference model.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [31:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [3][16];

    register_file #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_std (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .rdata_a(rda0), .raddr_b(raddr_b), .rdata_b(rdb0));

    register_file #(.WIDTH(32), .DEPTH(12), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_d12 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .rdata_a(rda1), .raddr_b(raddr_b), .rdata_b(rdb1));

    register_file #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .rdata_a(rda2), .raddr_b(raddr_b), .rdata_b(rdb2));

    function automatic int dep(input int d);
        return (d == 1) ? 12 : 16;
    endfunction

    function automatic bit zr(input int d);
        return d != 2;
    endfunction

    function automatic bit bp(input int d);
        return d != 2;
    endfunction

    // Expected read value straight from the behavioural rules.
    function automatic logic [31:0] mread(input int d, input logic [3:0] a);
        if (int'(a) >= dep(d)) return 32'h0;
        if (zr(d) && a == 4'd0) return 32'h0;
        if (bp(d) && we && !clr && a == waddr) return wdata;
        return mdl[d][a];
    endfunction

    function automatic logic [31:0] act_a(input int d);
        case (d)
            0: return rda0;
            1: return rda1;
            default: return rda2;
        endcase
    endfunction

    function automatic logic [31:0] act_b(input int d);
        case (d)
            0: return rdb0;
            1: return rdb1;
            default: return rdb2;
        endcase
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (clr) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            if (we && int'(waddr) < dep(d) && !(zr(d) && waddr == 4'd0))
                mdl[d][waddr] = wdata;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string nm);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s dut%0d A[%0d]", nm, d, raddr_a), act_a(d), mread(d, raddr_a));
            check($sformatf("%s dut%0d B[%0d]", nm, d, raddr_b), act_b(d), mread(d, raddr_b));
        end
    endtask

    task automatic tick();
        model_edge();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        we = 1'b1; waddr = a; wdata = v; clr = 1'b0;
        tick();
        we = 1'b0;
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic        clr;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs[7];

    initial begin
        clk = 0; rst_n = 1; we = 0; waddr = 0; wdata = 0; clr = 0; raddr_a = 0; raddr_b = 0;
        #3;

        // Asynchronous reset without any clock edge.
        rst_n = 1'b0;
        model_clear();
        #2;
        for (int i = 1; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(16 - i);
            #1;
            check_all("reset");
            check("reset std A", rda0, 32'h0);
        end
        rst_n = 1'b1;
        #2;

        // Expected values for the default build, read back after each edge with we=0.
        vecs[0] = '{1'b1, 4'd5,  32'h36D54B68, 1'b0, 4'd5,  4'd4,  32'h36D54B68, 32'h0};
        vecs[1] = '{1'b1, 4'd5,  32'hAC6D2299, 1'b0, 4'd5,  4'd4,  32'hAC6D2299, 32'h0};
        vecs[2] = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b0, 4'd0,  4'd5,  32'h0,        32'hAC6D2299};
        vecs[3] = '{1'b1, 4'd15, 32'h00000F0F, 1'b0, 4'd15, 4'd0,  32'h00000F0F, 32'h0};
        vecs[4] = '{1'b0, 4'd3,  32'hDEADBEEF, 1'b0, 4'd3,  4'd15, 32'h0,        32'h00000F0F};
        vecs[5] = '{1'b1, 4'd3,  32'h00001234, 1'b1, 4'd3,  4'd5,  32'h0,        32'h0};
        vecs[6] = '{1'b1, 4'd1,  32'hCAFE0001, 1'b0, 4'd1,  4'd15, 32'hCAFE0001, 32'h0};
        for (int v = 0; v < 7; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata; clr = vecs[v].clr;
            tick();
            we = 1'b0; clr = 1'b0;
            raddr_a = vecs[v].ra; raddr_b = vecs[v].rb;
            #1;
            check($sformatf("vec%0d A", v), rda0, vecs[v].ea);
            check($sformatf("vec%0d B", v), rdb0, vecs[v].eb);
            check_all($sformatf("vec%0d", v));
        end

        // Hold: wdata wiggles with clk low and we=0 change nothing.
        reset_pulse();
        wr(4'd5, 32'h36D54B68);
        raddr_a = 4'd5; raddr_b = 4'd4;
        wdata = 32'h63F5B504; #2;
        wdata = 32'hAC6D2299; #2;
        check("hold addr5", rda0, 32'h36D54B68);
        check_all("hold");
        wr(4'd5, 32'hAC6D2299);
        check("overwrite addr5", rda0, 32'hAC6D2299);
        check("overwrite addr4", rdb0, 32'h0);

        // Zero register and out-of-range writes on the DEPTH=12 build.
        for (int i = 1; i < 12; i++) wr(4'(i), 32'h1000_0000 + 32'(i));
        wr(4'd0, 32'hFFFFFFFF);
        wr(4'd13, 32'hFFFFFFFF);
        raddr_a = 4'd0; raddr_b = 4'd13; #1;
        check("d12 addr0", rda1, 32'h0);
        check("d12 addr13", rdb1, 32'h0);
        check("nozero addr0", rda2, 32'hFFFFFFFF);
        for (int i = 1; i < 12; i++) begin
            raddr_a = 4'(i); #1;
            check($sformatf("d12 keep %0d", i), rda1, 32'h1000_0000 + 32'(i));
        end

        // Bypass versus stored read in the same cycle.
        wr(4'd8, 32'h13579BDF);
        wr(4'd7, 32'h0BADF00D);
        we = 1'b1; waddr = 4'd7; wdata = 32'hAB28D21B; raddr_a = 4'd7; raddr_b = 4'd8;
        #1;
        check("bypass A", rda0, 32'hAB28D21B);
        check("bypass B", rdb0, 32'h13579BDF);
        check("nobypass A", rda2, 32'h0BADF00D);
        check_all("bypass");
        tick();
        we = 1'b0; #1;
        check("nobypass after edge", rda2, 32'hAB28D21B);

        // Clear wins over a simultaneous write.
        wr(4'd1, 32'h11111111);
        wr(4'd2, 32'h22222222);
        wr(4'd3, 32'h33333333);
        we = 1'b1; clr = 1'b1; waddr = 4'd2; wdata = 32'h1234; raddr_a = 4'd2; raddr_b = 4'd3;
        #1;
        check("clr no bypass", rda0, 32'h22222222);
        tick();
        we = 1'b0; clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(i); #1;
            check($sformatf("cleared %0d", i), rda0, 32'h0);
            check_all("cleared");
        end

        // Reset pulsed during a pending write with clk low.
        wr(4'd3, 32'h77777777);
        we = 1'b1; waddr = 4'd3; wdata = 32'h5A5A5A5A; raddr_a = 4'd3; raddr_b = 4'd3;
        #1;
        reset_pulse();
        check("midreset addr3", rda2, 32'h0);
        check_all("midreset");
        tick();
        we = 1'b0; #1;
        check("after reset write", rda2, 32'h5A5A5A5A);
        check("after reset write std", rda0, 32'h5A5A5A5A);

        // Randomized traffic against the model, checked before each edge.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 3) != 0);
            clr = 1'($urandom_range(0, 15) == 0);
            waddr = 4'($urandom);
            wdata = $urandom;
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            raddr_b = 4'($urandom);
            #1;
            check_all("rand");
            if ($urandom_range(0, 63) == 0) begin
                reset_pulse();
                check_all("rand reset");
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
